arbiter_game_n: RTL and testbench

- Parametrised successor of the two-player arbiter game: N players, a configurable LED countdown bar, false-start detection and tie-break mode.
- Adds a timeout when nobody presses, saturating per-player score counters, and a score read-back mux.
- Sits at top level between the debounced-free player buttons and the LED outputs, as the single game controller.

---
 rtl/arbiter_game_n_if.sv | 29 ++
 rtl/arbiter_game_n.sv | 169 ++++++++++++++++
 tb/tb_arbiter_game_n.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/arbiter_game_n_if.sv
// Player/LED bus of the N-player arbiter game controller.
// The controller side uses the slave modport, the stimulus side uses master.
interface arbiter_game_n_if #(
    parameter int N_PLAYERS = 4,
    parameter int LED_COUNT = 4,
    parameter int SCORE_W   = 4
);
    localparam int SEL_W = $clog2(N_PLAYERS);

    logic [N_PLAYERS-1:0] req_n_in;
    logic                 start_in;
    logic [SEL_W-1:0]     score_sel_in;
    logic [LED_COUNT-1:0] leds_out;
    logic [N_PLAYERS-1:0] winner_out;
    logic [N_PLAYERS-1:0] foul_out;
    logic                 busy_out;
    logic                 done_out;
    logic [SCORE_W-1:0]   score_out;

    modport master (
        output req_n_in, start_in, score_sel_in,
        input  leds_out, winner_out, foul_out, busy_out, done_out, score_out
    );

    modport slave (
        input  req_n_in, start_in, score_sel_in,
        output leds_out, winner_out, foul_out, busy_out, done_out, score_out
    );
endinterface

// File: rtl/arbiter_game_n.sv
// N-player reaction game controller: LED countdown, false-start detection,
// first-eligible-press arbitration (fixed or round-robin), timeout,
// winner blink display and saturating per-player scores.
module arbiter_game_n #(
    parameter int N_PLAYERS       = 4,
    parameter int LED_COUNT       = 4,
    parameter int PRESCALER_COUNT = 250,
    parameter int TIMEOUT_TICKS   = 16,
    parameter int WIN_BLINKS      = 6,
    parameter int TIE_MODE        = 0,
    parameter int SCORE_W         = 4
) (
    input  logic              clk,
    input  logic              rst_in_n,
    arbiter_game_n_if.slave   bus
);
    localparam int IDX_W   = $clog2(N_PLAYERS);
    localparam int PRE_W   = $clog2(PRESCALER_COUNT);
    localparam int CNT_MAX = (TIMEOUT_TICKS > WIN_BLINKS) ? TIMEOUT_TICKS : WIN_BLINKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, COUNTDOWN, ARMED, WIN_SHOW} state_t;

    state_t               state;
    logic [N_PLAYERS-1:0] req_meta;
    logic [N_PLAYERS-1:0] req;
    logic [PRE_W-1:0]     presc;
    logic                 tick;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     last;
    logic [SCORE_W-1:0]   score [N_PLAYERS];
    logic [LED_COUNT-1:0] leds;
    logic [N_PLAYERS-1:0] winner;
    logic [N_PLAYERS-1:0] foul;
    logic                 busy;
    logic                 done;
    logic [N_PLAYERS-1:0] eligible;
    logic [N_PLAYERS-1:0] foul_next;
    logic                 found;
    logic [IDX_W-1:0]     pick;
    int unsigned          idx;
    logic [SCORE_W-1:0]   score_mux;

    // Two-flop synchroniser on the inverted (active-high) player buttons
    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            req_meta <= '0;
            req      <= '0;
        end else begin
            req_meta <= ~bus.req_n_in;
            req      <= req_meta;
        end
    end

    assign tick      = (presc == PRE_W'(PRESCALER_COUNT - 1));
    assign foul_next = foul | req;

    // Winner search: lowest index, or first eligible after the last winner
    always_comb begin
        eligible = req & ~foul;
        found    = 1'b0;
        pick     = '0;
        idx      = 0;
        for (int unsigned s = 0; s < N_PLAYERS; s++) begin
            idx = (TIE_MODE != 0) ? (32'(last) + 1 + s) % N_PLAYERS : s;
            if (!found && eligible[IDX_W'(idx)]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    // Score read-back mux; out-of-range selections read as zero
    always_comb begin
        score_mux = '0;
        if ({1'b0, bus.score_sel_in} < (IDX_W + 1)'(N_PLAYERS))
            score_mux = score[bus.score_sel_in];
    end

    // Round state machine with registered outputs; prescaler restarts on every state entry
    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state  <= IDLE;
            presc  <= '0;
            cnt    <= '0;
            last   <= IDX_W'(N_PLAYERS - 1);
            leds   <= '0;
            winner <= '0;
            foul   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            for (int unsigned i = 0; i < N_PLAYERS; i++) score[i] <= '0;
        end else begin
            done  <= 1'b0;
            presc <= tick ? '0 : presc + 1'b1;
            unique case (state)
                IDLE: begin
                    leds <= '0;
                    if (bus.start_in) begin
                        state  <= COUNTDOWN;
                        presc  <= '0;
                        foul   <= '0;
                        winner <= '0;
                        leds   <= '1;
                        busy   <= 1'b1;
                    end
                end
                COUNTDOWN: begin
                    foul <= foul_next;
                    if (tick) begin
                        leds <= leds >> 1;
                        if (leds == LED_COUNT'(1)) begin
                            presc <= '0;
                            cnt   <= '0;
                            if (&foul_next) begin
                                state <= IDLE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state <= ARMED;
                            end
                        end
                    end
                end
                ARMED: begin
                    // A win in the same cycle as the final timeout tick still wins
                    if (found) begin
                        winner <= N_PLAYERS'(1) << pick;
                        last   <= pick;
                        if (score[pick] != '1) score[pick] <= score[pick] + 1'b1;
                        state  <= WIN_SHOW;
                        leds   <= '1;
                        presc  <= '0;
                        cnt    <= '0;
                    end else if (tick) begin
                        if (cnt == CNT_W'(TIMEOUT_TICKS - 1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                WIN_SHOW: begin
                    if (tick) begin
                        if (cnt == CNT_W'(WIN_BLINKS - 1)) begin
                            leds  <= '0;
                            state <= IDLE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            leds <= ~leds;
                            cnt  <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.leds_out   = leds;
    assign bus.winner_out = winner;
    assign bus.foul_out   = foul;
    assign bus.busy_out   = busy;
    assign bus.done_out   = done;
    assign bus.score_out  = score_mux;
endmodule

// File: tb/tb_arbiter_game_n.sv
// Bench for arbiter_game_n: one fixed-priority and one round-robin instance
// driven by the same buttons, checked cycle by cycle against a round-level model.
module tb_arbiter_game_n;
    localparam int NP = 4;
    localparam int LC = 4;
    localparam int PC = 4;
    localparam int TO = 3;
    localparam int WB = 2;
    localparam int SW = 4;
    localparam int CD_END  = LC * PC;          // edge that leaves the countdown
    localparam int TO_END  = CD_END + TO * PC; // edge of the timeout
    localparam int WIN_LAT = 3;                // press -> winner visible (sync + decide)

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NP-1:0] req_n = '1;
    logic          start = 1'b0;
    logic [1:0]    sel = '0;

    int n_vec = 0;
    int n_err = 0;

    // model state
    int score_m [2][NP];
    int last_rr;

    arbiter_game_n_if #(.N_PLAYERS(NP), .LED_COUNT(LC), .SCORE_W(SW)) bus0 ();
    arbiter_game_n_if #(.N_PLAYERS(NP), .LED_COUNT(LC), .SCORE_W(SW)) bus1 ();

    assign bus0.req_n_in = req_n;
    assign bus0.start_in = start;
    assign bus0.score_sel_in = sel;
    assign bus1.req_n_in = req_n;
    assign bus1.start_in = start;
    assign bus1.score_sel_in = sel;

    arbiter_game_n #(.N_PLAYERS(NP), .LED_COUNT(LC), .PRESCALER_COUNT(PC), .TIMEOUT_TICKS(TO),
                     .WIN_BLINKS(WB), .TIE_MODE(0), .SCORE_W(SW))
        dut0 (.clk(clk), .rst_in_n(rst_n), .bus(bus0));
    arbiter_game_n #(.N_PLAYERS(NP), .LED_COUNT(LC), .PRESCALER_COUNT(PC), .TIMEOUT_TICKS(TO),
                     .WIN_BLINKS(WB), .TIE_MODE(1), .SCORE_W(SW))
        dut1 (.clk(clk), .rst_in_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    logic [3:0] leds_o [2], win_o [2], foul_o [2], score_o [2];
    logic       busy_o [2], done_o [2];
    assign leds_o[0] = bus0.leds_out;   assign leds_o[1] = bus1.leds_out;
    assign win_o[0]  = bus0.winner_out; assign win_o[1]  = bus1.winner_out;
    assign foul_o[0] = bus0.foul_out;   assign foul_o[1] = bus1.foul_out;
    assign score_o[0] = bus0.score_out; assign score_o[1] = bus1.score_out;
    assign busy_o[0] = bus0.busy_out;   assign busy_o[1] = bus1.busy_out;
    assign done_o[0] = bus0.done_out;   assign done_o[1] = bus1.done_out;

    typedef struct {
        logic [3:0] fouls;
        logic [3:0] presses;
        int         d;
        logic [3:0] w0;
        logic [3:0] w1;
    } round_t;

    round_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] model_pick(input logic [3:0] elig, input int rr, input int last);
        int p;
        for (int s = 0; s < NP; s++) begin
            p = rr ? (last + 1 + s) % NP : s;
            if (elig[p]) return 4'(1 << p);
        end
        return 4'h0;
    endfunction

    function automatic int onehot_idx(input logic [3:0] oh);
        for (int i = 0; i < NP; i++) if (oh[i]) return i;
        return 0;
    endfunction

    task automatic check_scores(input string tag);
        for (int s = 0; s < NP; s++) begin
            sel = 2'(s);
            #1;
            for (int m = 0; m < 2; m++)
                chk($sformatf("%s score m%0d p%0d", tag, m, s), 32'(score_o[m]), 32'(score_m[m][s]));
        end
    endtask

    // One full round: fouls held during countdown, presses applied d cycles after ARMED entry
    task automatic play_round(input string tag, input logic [3:0] fouls, input logic [3:0] presses,
                              input int d, input logic [3:0] ew0, input logic [3:0] ew1);
        bit allf, win;
        int w_at, e_at;
        logic [3:0] exp_leds, ew [2];
        ew[0] = ew0;
        ew[1] = ew1;
        allf = (fouls == 4'hF);
        win  = !allf && (ew0 != 0);
        w_at = CD_END + d + WIN_LAT;
        e_at = allf ? CD_END : (win ? w_at + WB * PC : TO_END);

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k <= e_at + 1; k++) begin
            if (k > 0) @(negedge clk);
            if (k < CD_END)
                exp_leds = 4'((1 << (LC - k / PC)) - 1);
            else if (win && k >= w_at && k < e_at)
                exp_leds = (((k - w_at) / PC) % 2 == 0) ? 4'hF : 4'h0;
            else
                exp_leds = 4'h0;
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("%s m%0d k%0d leds", tag, m, k), 32'(leds_o[m]), 32'(exp_leds));
                chk($sformatf("%s m%0d k%0d busy", tag, m, k), 32'(busy_o[m]), 32'(k < e_at));
                chk($sformatf("%s m%0d k%0d done", tag, m, k), 32'(done_o[m]), 32'(k == e_at));
                chk($sformatf("%s m%0d k%0d winner", tag, m, k), 32'(win_o[m]),
                    32'((win && k >= w_at) ? ew[m] : 4'h0));
                if (k < 5)
                    chk($sformatf("%s m%0d k%0d foul clr", tag, m, k), 32'(foul_o[m]), 32'h0);
                else if (k >= 8)
                    chk($sformatf("%s m%0d k%0d foul", tag, m, k), 32'(foul_o[m]), 32'(fouls));
            end
            if (k == 2 && fouls != 0) req_n = ~fouls;
            if (k == 5) req_n = '1;
            if (!allf && k == CD_END + d) req_n = ~presses;
            if (k == e_at + 1) req_n = '1;
        end
        if (win) begin
            for (int m = 0; m < 2; m++)
                if (score_m[m][onehot_idx(ew[m])] < 15) score_m[m][onehot_idx(ew[m])]++;
            last_rr = onehot_idx(ew1);
        end
        check_scores(tag);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] f, p, elig, e0, e1;
        int d;

        tbl[0] = '{4'h0, 4'hA, 0, 4'h2, 4'h2};
        tbl[1] = '{4'h0, 4'hA, 0, 4'h2, 4'h8};
        tbl[2] = '{4'h0, 4'hA, 0, 4'h2, 4'h2};
        tbl[3] = '{4'h0, 4'h4, 0, 4'h4, 4'h4};
        tbl[4] = '{4'h1, 4'h3, 1, 4'h2, 4'h2};
        tbl[5] = '{4'h0, 4'h0, 0, 4'h0, 4'h0};
        tbl[6] = '{4'hF, 4'h0, 0, 4'h0, 4'h0};
        tbl[7] = '{4'h0, 4'h1, 9, 4'h1, 4'h1};
        tbl[8] = '{4'h4, 4'h4, 2, 4'h0, 4'h0};

        for (int m = 0; m < 2; m++) for (int i = 0; i < NP; i++) score_m[m][i] = 0;
        last_rr = NP - 1;

        #12;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("reset m%0d leds", m), 32'(leds_o[m]), 32'h0);
            chk($sformatf("reset m%0d busy", m), 32'(busy_o[m]), 32'h0);
            chk($sformatf("reset m%0d done", m), 32'(done_o[m]), 32'h0);
            chk($sformatf("reset m%0d winner", m), 32'(win_o[m]), 32'h0);
            chk($sformatf("reset m%0d foul", m), 32'(foul_o[m]), 32'h0);
            chk($sformatf("reset m%0d score", m), 32'(score_o[m]), 32'h0);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++)
            play_round($sformatf("tbl%0d", i), tbl[i].fouls, tbl[i].presses, tbl[i].d, tbl[i].w0, tbl[i].w1);

        // asynchronous reset in the middle of the countdown
        sel = 2'd1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (6) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("pre-rst m%0d busy", m), 32'(busy_o[m]), 32'h1);
            chk($sformatf("pre-rst m%0d leds", m), 32'(leds_o[m]), 32'h7);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("async-rst m%0d leds", m), 32'(leds_o[m]), 32'h0);
            chk($sformatf("async-rst m%0d busy", m), 32'(busy_o[m]), 32'h0);
            chk($sformatf("async-rst m%0d winner", m), 32'(win_o[m]), 32'h0);
            chk($sformatf("async-rst m%0d foul", m), 32'(foul_o[m]), 32'h0);
            chk($sformatf("async-rst m%0d score", m), 32'(score_o[m]), 32'h0);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int m = 0; m < 2; m++) for (int i = 0; i < NP; i++) score_m[m][i] = 0;
        last_rr = NP - 1;
        repeat (2) @(negedge clk);

        // saturation: player 0 wins 17 rounds
        for (int r = 0; r < 17; r++)
            play_round($sformatf("sat%0d", r), 4'h0, 4'h1, 0, 4'h1, 4'h1);
        sel = 2'd0;
        #1;
        for (int m = 0; m < 2; m++)
            chk($sformatf("saturated m%0d", m), 32'(score_o[m]), 32'd15);

        // randomized rounds against the round-level model
        for (int r = 0; r < 25; r++) begin
            f = 4'($urandom) & 4'($urandom);
            p = 4'($urandom_range(0, 15));
            d = $urandom_range(0, 11);
            elig = (f == 4'hF || CD_END + d + WIN_LAT > TO_END) ? 4'h0 : (p & ~f);
            e0 = model_pick(elig, 0, 0);
            e1 = model_pick(elig, 1, last_rr);
            play_round($sformatf("rnd%0d", r), f, p, d, e0, e1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
